// File: rtl/fpu_instruction_queue_if.sv
// CPU-byte / decoder-word handshake bundle for the FPU instruction queue.
interface fpu_instruction_queue_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   logic             flush;
   logic [7:0]       byte_in;
   logic             byte_valid;
   logic             byte_ready;
   logic [15:0]      instruction;
   logic             decode;
   logic             instr_ack;
   logic [CNT_W-1:0] count;
   logic             full;

   // Environment side: CPU byte source and decoder consumer
   modport master (
      output flush, byte_in, byte_valid, instr_ack,
      input  byte_ready, instruction, decode, count, full
   );

   // Queue side
   modport slave (
      input  flush, byte_in, byte_valid, instr_ack,
      output byte_ready, instruction, decode, count, full
   );
endinterface

// File: rtl/fpu_instruction_queue.sv
// Pairs ESC opcode bytes with their ModRM and buffers the 16-bit words
// in a first-word-fall-through FIFO for the FPU decoder.
module fpu_instruction_queue #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   fpu_instruction_queue_if.slave  q
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WAIT_MODRM = 2'd1,
      HOLD       = 2'd2
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [7:0]        opcode_q;
   logic [7:0]        modrm_q;
   logic [15:0]       mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  cnt;

   logic              clear;
   logic              is_full;
   logic              is_empty;
   logic              pop;
   logic              write_ok;
   logic              accept;
   logic              is_esc;
   logic              push;
   logic [15:0]       push_word;
   logic              byte_rdy;

   assign clear     = reset || q.flush;
   assign is_full   = (cnt == CNT_W'(DEPTH));
   assign is_empty  = (cnt == '0);
   assign pop       = q.instr_ack && !is_empty;
   // A same-cycle pop frees the slot the push needs
   assign write_ok  = !is_full || pop;
   assign accept    = q.byte_valid && byte_rdy;
   assign is_esc    = (q.byte_in[7:3] == 5'b11011);
   assign push      = ((state_q == WAIT_MODRM) && accept && write_ok) ||
                      ((state_q == HOLD) && write_ok);
   assign push_word = (state_q == HOLD) ? {opcode_q, modrm_q} : {opcode_q, q.byte_in};

   // Assembler state register; flush and reset both return to IDLE
   always_ff @(posedge clk) begin
      if (clear) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Assembler next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (accept && is_esc) state_d = WAIT_MODRM;
         WAIT_MODRM: if (accept)           state_d = write_ok ? IDLE : HOLD;
         HOLD:       if (write_ok)         state_d = IDLE;
         default:                          state_d = IDLE;
      endcase
   end

   // Assembler outputs: bytes are refused only while a word is parked
   always_comb begin
      byte_rdy = 1'b1;
      if (state_q == HOLD) byte_rdy = 1'b0;
   end

   // Opcode / ModRM latches
   always_ff @(posedge clk) begin
      if (clear) begin
         opcode_q <= '0;
         modrm_q  <= '0;
      end else begin
         if ((state_q == IDLE) && accept && is_esc)             opcode_q <= q.byte_in;
         if ((state_q == WAIT_MODRM) && accept && !write_ok)    modrm_q  <= q.byte_in;
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk) begin
      if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         if (push && !pop)      cnt <= cnt + CNT_W'(1);
         else if (pop && !push) cnt <= cnt - CNT_W'(1);
      end
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (!clear && push) mem[wr_ptr] <= push_word;
   end

   assign q.byte_ready  = byte_rdy;
   assign q.decode      = !is_empty;
   assign q.instruction = is_empty ? 16'h0000 : mem[rd_ptr];
   assign q.count       = cnt;
   assign q.full        = is_full;
endmodule

// File: doc/fpu_instruction_queue.md
# fpu_instruction_queue

ESC-instruction capture and buffering stage that sits directly upstream of the FPU instruction decoder. Accepts the CPU-to-FPU byte stream, recognises ESC opcode bytes (D8h–DFh), pairs each with the following ModRM byte into a 16-bit instruction word {opcode, modrm}, and buffers those words in a small FIFO. Words are presented to the decoder in first-word-fall-through order on its `instruction`/`decode` inputs, with an acknowledge-based pop.

## Interface
Parameters:
- DEPTH, 4, number of buffered instruction words; must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of the FIFO and the assembler, e.g. on FINIT or a CPU pipeline flush.
- byte_in  in  8  instruction byte from the CPU side.
- byte_valid  in  1  byte_in is valid this cycle.
- byte_ready  out  1  queue accepts byte_in this cycle. A byte transfers when byte_valid && byte_ready.
- instruction  out  16  head word {opcode[15:8], modrm[7:0]}; 16'h0000 when empty.
- decode  out  1  head word valid; equals !empty.
- instr_ack  in  1  consumer pops the head. Ignored when decode=0.
- count  out  $clog2(DEPTH)+1  number of words currently held.
- full  out  1  count == DEPTH.

## Operation
- The upstream source delivers only opcode and ModRM bytes. Displacement bytes are consumed by the CPU effective-address logic and never appear here.
- Assembler FSM, with states IDLE, WAIT_MODRM and HOLD:
  - IDLE: an accepted byte with byte_in[7:3]==5'b11011 is latched as the opcode, and the FSM goes to WAIT_MODRM. Any other accepted byte (including FWAIT 9Bh and prefixes) is discarded, and the FSM stays in IDLE.
  - WAIT_MODRM: the next accepted byte is the ModRM, whatever its value (an ESC-valued byte is also treated as ModRM).
    - If a write is permitted, {opcode, byte} is written and the FSM goes to IDLE.
    - Otherwise the ModRM is latched and the FSM goes to HOLD.
  - HOLD: the FSM waits for a permitted write, then writes the latched word and goes to IDLE.
- byte_ready = (state != HOLD). It is high in IDLE and WAIT_MODRM regardless of FIFO occupancy.
- Write is permitted when !full || (instr_ack && decode), i.e. a simultaneous pop frees the slot in the same cycle.
- FIFO:
  - Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH.
  - count increments on push only, decrements on pop only, and is unchanged on simultaneous push and pop.
  - Words are delivered strictly in arrival order. No word is ever dropped or duplicated.
- Flush and reset have identical effect:
  - count becomes 0 and both pointers become 0.
  - The FSM goes to IDLE, and any latched opcode or ModRM is discarded.
  - Any byte presented or acked in the same cycle is ignored, i.e. flush/reset win over byte_valid, instr_ack and any write.

## Timing
- Reset values:
  - decode=0, instruction=16'h0000, count=0, full=0, byte_ready=1.
  - FSM in IDLE.
- Latency: when the ModRM is accepted on edge N with space available, decode=1 and instruction=word from after edge N. Two byte cycles minimum per instruction; back-to-back instructions sustain one byte per cycle.
- HOLD exit: the write occurs on the first edge where a write is permitted. byte_ready rises after that edge.
- Pop: on the edge with instr_ack && decode, the head advances. The next word (or 16'h0000 with decode=0) is visible after that edge.
- Outputs: instruction, decode, count and full are derived only from registered state. byte_ready depends only on FSM state. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** assert reset 2 cycles. Required: decode=0, instruction=0000, count=0, full=0, byte_ready=1.
- **Basic capture:** bytes D8, C3 on consecutive cycles, instr_ack=0.
  - Required: the cycle after C3, decode=1, instruction=D8C3, count=1.
  - Then ack one cycle. Required: decode=0, instruction=0000, count=0.
- **Filtering:** bytes 90, 9B, D9, E8. Required: exactly one word D9E8, count=1.
- **Full and HOLD:**
  - Push DEC1, DED9, DFF7, DB06 with no ack. Required: full=1.
  - Send DD, 06. Required: byte_ready=0 after 06 (HOLD).
  - Ack once. Required: after the following edge, count=4, byte_ready=1.
  - Drain. Required: order DED9, DFF7, DB06, DD06.
- **Full with simultaneous pop:** FIFO full, WAIT_MODRM after DD. Present 06 together with instr_ack. Required: no HOLD (byte_ready stays 1), count stays 4, DD06 at tail.
- **Flush:**
  - Send D9, then flush with byte F0 valid in the same cycle, then byte F0 alone. Required: count=0, decode=0, FSM in IDLE; the F0 is discarded as a non-ESC byte.
  - Repeat with a full FIFO plus instr_ack during flush. Required: count=0.
